fm2151_wrsched: RTL and testbench

Register-write scheduler and host status port for the jt51 YM2151 core in the NORA FPGA. Host register writes are (address, data) pairs; the block queues them in a FIFO and replays each pair onto the jt51 bus as two writes: the address byte with a0=0, then the data byte with a0=1. Writes are paced by the FM clock-enable. After every data write the block waits for the core's busy flag (status bit 7) to clear, so host software never needs to poll busy. The block sits between the host bus decoder and the `fm2151` wrapper, and takes its `cen` from the 3.57 MHz clock-enable generator.

---
 rtl/fm2151_wrsched.sv | 184 ++++++++++++++++++
 tb/tb_fm2151_wrsched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm2151_wrsched.sv
// rtl/fm2151_wrsched.sv - YM2151 register-write scheduler with FIFO, cen pacing and busy wait
module fm2151_wrsched #(
    parameter int DEPTH    = 16,
    parameter int MIN_WAIT = 2,
    parameter int BUSY_TMO = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [7:0]               wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [7:0]               rd_status,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     tmo_err,
    output logic                     fm_cs_n,
    output logic                     fm_wr_n,
    output logic                     fm_a0,
    output logic [7:0]               fm_din,
    input  logic [7:0]               fm_dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 16;
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_WR,
        GAP,
        DATA_WR,
        BUSY_WAIT
    } state_t;

    state_t         state, state_next;
    logic [15:0]    mem [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [15:0]    head;
    logic           empty, full, push, pop, start, keep_head, tmo_set;
    logic           cs_n_next, wr_n_next, a0_next;
    logic [7:0]     din_next;
    logic [CW-1:0]  cnt, cnt_next, cnt_inc;

    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (fifo_level == LVL_FULL);
    assign wr_ready   = ~rst & ~full & ~flush;
    assign push       = wr_valid & wr_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign busy       = ~empty | (state != IDLE);

    // The head stays in the FIFO until its data write ends, so a flush
    // while a pair is in flight must preserve exactly that one entry.
    assign keep_head  = start | (state == ADDR_WR) | (state == GAP) | (state == DATA_WR);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (flush) begin
                wr_ptr <= keep_head ? rd_ptr + PTR_ONE : rd_ptr;
            end else if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        state_next = state;
        cs_n_next  = fm_cs_n;
        wr_n_next  = fm_wr_n;
        a0_next    = fm_a0;
        din_next   = fm_din;
        cnt_next   = cnt;
        cnt_inc    = cnt + CW'(1);
        pop        = 1'b0;
        start      = 1'b0;
        tmo_set    = 1'b0;
        case (state)
            IDLE: begin
                if (cen && !empty) begin
                    a0_next    = 1'b0;
                    din_next   = head[15:8];
                    cs_n_next  = 1'b0;
                    wr_n_next  = 1'b0;
                    start      = 1'b1;
                    state_next = ADDR_WR;
                end
            end
            ADDR_WR: begin
                if (cen) begin
                    cs_n_next  = 1'b1;
                    wr_n_next  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (cen) begin
                    a0_next    = 1'b1;
                    din_next   = head[7:0];
                    cs_n_next  = 1'b0;
                    wr_n_next  = 1'b0;
                    state_next = DATA_WR;
                end
            end
            DATA_WR: begin
                if (cen) begin
                    cs_n_next  = 1'b1;
                    wr_n_next  = 1'b1;
                    pop        = 1'b1;
                    cnt_next   = '0;
                    state_next = BUSY_WAIT;
                end
            end
            BUSY_WAIT: begin
                // busy is ignored until the core has had time to raise it
                if (cen) begin
                    if (cnt_inc > CW'(MIN_WAIT) && !fm_dout[7]) begin
                        state_next = IDLE;
                    end else if (cnt_inc >= CW'(BUSY_TMO)) begin
                        tmo_set    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cs_n_next  = 1'b1;
                wr_n_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fm_cs_n <= 1'b1;
            fm_wr_n <= 1'b1;
            fm_a0   <= 1'b0;
            fm_din  <= 8'h00;
            cnt     <= '0;
            tmo_err <= 1'b0;
        end else begin
            state   <= state_next;
            fm_cs_n <= cs_n_next;
            fm_wr_n <= wr_n_next;
            fm_a0   <= a0_next;
            fm_din  <= din_next;
            cnt     <= cnt_next;
            if (tmo_set) begin
                tmo_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack    <= 1'b0;
            rd_status <= 8'h00;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_status <= {fm_dout[7] | busy, fm_dout[6:0]};
            end
        end
    end
endmodule

// File: tb/tb_fm2151_wrsched.sv
// tb/tb_fm2151_wrsched.sv - directed self-checking bench for fm2151_wrsched
module tb_fm2151_wrsched;
    localparam int P = 4;

    logic       clk = 1'b0, rst = 1'b1, cen = 1'b0;
    logic       wr_valid = 1'b0, flush = 1'b0, rd_req = 1'b0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, fm_dout = 8'h00;
    logic       wr_ready, rd_ack, busy, tmo_err, fm_cs_n, fm_wr_n, fm_a0;
    logic [7:0] rd_status, fm_din;
    logic [4:0] fifo_level;

    int total = 0, bad = 0, cyc = 0;
    bit cen_en = 1'b0;

    typedef struct {
        logic       a0;
        logic [7:0] din;
        int         start;
        int         stop;
        int         level;
    } rec_t;
    rec_t recs[$];
    rec_t cur;
    int   busy_fall = 0, wr_viol = 0, unstable = 0;
    logic prev_wr_n = 1'b1, prev_busy = 1'b0;

    fm2151_wrsched dut (
        .clk(clk), .rst(rst), .cen(cen),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .rd_req(rd_req), .rd_ack(rd_ack), .rd_status(rd_status),
        .busy(busy), .fifo_level(fifo_level), .tmo_err(tmo_err),
        .fm_cs_n(fm_cs_n), .fm_wr_n(fm_wr_n), .fm_a0(fm_a0), .fm_din(fm_din), .fm_dout(fm_dout)
    );

    always #5 clk = ~clk;

    // cen is high in every P-th cycle; a tick ends the cycle numbered cyc
    initial forever begin
        @(posedge clk);
        cyc++;
        #2 cen = cen_en && (cyc % P == 0);
    end

    initial forever begin
        @(negedge clk);
        if (!fm_wr_n && fm_cs_n) wr_viol++;
        if (prev_wr_n && !fm_wr_n) begin
            cur.a0 = fm_a0; cur.din = fm_din; cur.start = cyc;
        end else if (!prev_wr_n && !fm_wr_n) begin
            if (fm_a0 !== cur.a0 || fm_din !== cur.din) unstable++;
        end else if (!prev_wr_n && fm_wr_n) begin
            cur.stop = cyc; cur.level = int'(fifo_level);
            recs.push_back(cur);
        end
        if (prev_busy && !busy) busy_fall = cyc;
        prev_wr_n = fm_wr_n;
        prev_busy = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d, output bit acc);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1 acc = wr_ready;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (busy && n < max_cyc);
        check_eq(tag, 32'(busy), 0);
    endtask

    task automatic wait_recs(input string tag, input int cnt, input int max_cyc);
        int n = 0;
        while (recs.size() < cnt && n < max_cyc) begin
            @(negedge clk); #1; n++;
        end
        check_eq(tag, 32'(recs.size() >= cnt), 1);
    endtask

    initial begin
        bit acc;
        int ok_cnt, tx, e, n;

        repeat (2) @(negedge clk);
        #1 check_eq("rdy_in_rst", 32'(wr_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_strobes", {fm_cs_n, fm_wr_n, fm_a0}, 3'b110);
        check_eq("rst_din", fm_din, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_busy_tmo", {busy, tmo_err}, 0);
        check_eq("rst_rd", {rd_ack, rd_status}, 0);
        check_eq("rst_rdy", 32'(wr_ready), 1);

        // status read while idle
        @(negedge clk);
        fm_dout = 8'h03; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        #1 check_eq("rd_idle", {rd_ack, rd_status}, 9'h103);

        // single pair
        @(negedge clk);
        fm_dout = 8'h00; cen_en = 1'b1; recs.delete();
        push(8'h28, 8'h4A, acc);
        check_eq("sp_acc", 32'(acc), 1);
        wait_idle("sp_idle", 300);
        check_eq("sp_nrec", recs.size(), 2);
        if (recs.size() == 2) begin
            check_eq("sp_addr", {recs[0].a0, recs[0].din}, 9'h028);
            check_eq("sp_addr_len", recs[0].stop - recs[0].start, P);
            check_eq("sp_data", {recs[1].a0, recs[1].din}, 9'h14A);
            check_eq("sp_data_len", recs[1].stop - recs[1].start, P);
            check_eq("sp_gap", recs[1].start - recs[0].stop, P);
            check_eq("sp_busy_fall", busy_fall - recs[1].stop, 3 * P);
        end

        // fill and order
        cen_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        recs.delete();
        ok_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h20 + i), 8'(i * 7 + 1), acc);
            if (acc) ok_cnt++;
        end
        check_eq("fill_acc", ok_cnt, 16);
        push(8'hEE, 8'hEF, acc);
        check_eq("fill_17_acc", 32'(acc), 0);
        #1 check_eq("fill_level", fifo_level, 16);
        check_eq("fill_rdy", 32'(wr_ready), 0);
        cen_en = 1'b1;
        wait_idle("fill_idle", 1500);
        check_eq("fill_nrec", recs.size(), 32);
        if (recs.size() == 32) begin
            for (int i = 0; i < 16; i++) begin
                check_eq($sformatf("fill_addr%0d", i), {recs[2*i].a0, recs[2*i].din}, {1'b0, 8'(8'h20 + i)});
                check_eq($sformatf("fill_data%0d", i), {recs[2*i+1].a0, recs[2*i+1].din}, {1'b1, 8'(i * 7 + 1)});
                check_eq($sformatf("fill_lvl%0d", i), recs[2*i+1].level, 15 - i);
            end
        end

        // busy hold for 10 ticks
        @(negedge clk);
        recs.delete(); fm_dout = 8'h80;
        push(8'h30, 8'h31, acc);
        push(8'h32, 8'h33, acc);
        wait_recs("bh_recs2", 2, 200);
        n = 0;
        for (int k = 0; k < 200 && n < 10; k++) begin
            @(negedge clk); #1;
            if (cen) n++;
        end
        @(negedge clk);
        fm_dout = 8'h00;
        #1;
        for (int k = 0; k < P && !cen; k++) begin
            @(negedge clk); #1;
        end
        tx = cyc;
        wait_recs("bh_recs3", 3, 200);
        if (recs.size() >= 3) begin
            check_eq("bh_next_start", recs[2].start, tx + P + 1);
            check_eq("bh_next_addr", {recs[2].a0, recs[2].din}, 9'h032);
        end
        wait_idle("bh_idle", 300);

        // busy timeout
        @(negedge clk);
        recs.delete(); fm_dout = 8'h80;
        push(8'h40, 8'h41, acc);
        push(8'h42, 8'h43, acc);
        wait_recs("to_recs2", 2, 200);
        check_eq("to_err_before", 32'(tmo_err), 0);
        wait_recs("to_recs3", 3, 1500);
        if (recs.size() >= 3) begin
            e = recs[1].stop;
            check_eq("to_wait", recs[2].start - e, 256 * P);
            check_eq("to_next_addr", {recs[2].a0, recs[2].din}, 9'h042);
        end
        check_eq("to_err", 32'(tmo_err), 1);
        fm_dout = 8'h00;
        wait_idle("to_idle", 300);
        check_eq("to_nrec", recs.size(), 4);
        check_eq("to_err_sticky", 32'(tmo_err), 1);

        // flush during GAP of pair 1 with a concurrent push
        cen_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        recs.delete();
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i), 8'(8'h60 + i), acc);
        cen_en = 1'b1;
        wait_recs("fl_recs1", 1, 200);
        flush = 1'b1; wr_valid = 1'b1; wr_addr = 8'h77; wr_data = 8'h78;
        #1 check_eq("fl_rdy", 32'(wr_ready), 0);
        @(negedge clk);
        flush = 1'b0; wr_valid = 1'b0;
        #1 check_eq("fl_level_head", fifo_level, 1);
        wait_idle("fl_idle", 300);
        check_eq("fl_nrec", recs.size(), 2);
        if (recs.size() == 2) begin
            check_eq("fl_addr", {recs[0].a0, recs[0].din}, 9'h050);
            check_eq("fl_data", {recs[1].a0, recs[1].din}, 9'h160);
        end
        check_eq("fl_level_end", fifo_level, 0);

        // status read with queue non-empty
        cen_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fm_dout = 8'h03;
        push(8'h11, 8'h22, acc);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        #1 check_eq("rd_busy", {rd_ack, rd_status}, 9'h183);
        @(negedge clk);
        #1 check_eq("rd_ack_pulse", 32'(rd_ack), 0);

        // reset in the middle of ADDR_WR
        fm_dout = 8'h00;
        push(8'h12, 8'h23, acc);
        cen_en = 1'b1;
        n = 0;
        while (fm_cs_n && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check_eq("rs_cs_low", 32'(fm_cs_n), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rs_strobes", {fm_cs_n, fm_wr_n}, 2'b11);
        check_eq("rs_level", fifo_level, 0);
        check_eq("rs_busy", 32'(busy), 0);
        check_eq("rs_rdy", 32'(wr_ready), 0);
        rst = 1'b0;
        recs.delete();
        repeat (20 * P) @(negedge clk);
        #1;
        check_eq("rs_no_writes", recs.size(), 0);
        check_eq("rs_busy_after", 32'(busy), 0);

        check_eq("wr_without_cs", wr_viol, 0);
        check_eq("bus_unstable", unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
